pipeline_control_irq_call: RTL and testbench
============================================

# pipeline_control_irq_call

Interrupt-entry sequencer in the pipeline control unit; the entry-side counterpart of the interrupt-return sequencer. On a call request it saves the interrupted PC and PSR into the previous-context SPRs and reads the 8-byte IDT entry for the interrupt number over the load/store read port. It then redirects the fetch PC to the handler, or flags a fault if the entry is invalid. It completes with a single-cycle finish pulse to the pipeline controller.

## Interface
- No parameters.
- iCLOCK  in  1  core clock, all state on rising edge
- inRESET  in  1  asynchronous reset, active low
- iRESET_SYNC  in  1  synchronous reset, active high; same effect as inRESET, applied at the clock edge
- iCALL_START  in  1  call request pulse; accepted only in IDLE
- iCALL_IRQ_NUM  in  7  interrupt number, sampled with accepted start
- iCALL_PC  in  32  return PC, sampled with accepted start
- iCALL_PSR  in  32  current PSR, sampled with accepted start
- iSYSREG_IDTR  in  32  IDT base address, sampled with accepted start
- oLDST_REQ  out  1  read request, held until accepted
- oLDST_ADDR  out  32  read address, stable while oLDST_REQ
- iLDST_BUSY  in  1  port busy; request accepted in a cycle with oLDST_REQ && !iLDST_BUSY
- iLDST_VALID  in  1  read data valid
- iLDST_DATA  in  32  read data
- oPPCR_WR / oPPCR_DATA  out  1/32  previous-PC SPR write
- oPPSR_WR / oPPSR_DATA  out  1/32  previous-PSR SPR write
- oPC_SET / oPC_DATA  out  1/32  fetch redirect to handler
- oFAULT  out  1  invalid IDT entry, single-cycle pulse
- oBUSY  out  1  sequence in progress
- oFINISH  out  1  sequence complete (normal or fault), single-cycle pulse

## Operation
- States are IDLE, SAVE, FLAG_REQ, FLAG_WAIT, HDL_REQ, HDL_WAIT, DONE, FAULT, held in a 3-bit register.
- All outputs are registered or decoded from the state register only. No input reaches an output combinationally.
- IDLE: on iCALL_START, latch num, PC, PSR and IDTR, then go to SAVE. Otherwise stay.
- SAVE, one cycle:
  - oPPCR_WR=1 with oPPCR_DATA=latched PC.
  - oPPSR_WR=1 with oPPSR_DATA=latched PSR.
  - Next state is FLAG_REQ.
- FLAG_REQ: oLDST_REQ=1, oLDST_ADDR = IDTR + {num,3'b000}, computed modulo 2^32. Go to FLAG_WAIT when accepted.
- FLAG_WAIT: on iLDST_VALID, capture the data. Bit0=1 goes to HDL_REQ. Bit0=0 goes to FAULT.
- HDL_REQ: same rules as FLAG_REQ with address IDTR + {num,3'b000} + 4, modulo 2^32. Go to HDL_WAIT when accepted.
- HDL_WAIT: on iLDST_VALID, latch {iLDST_DATA[31:2],2'b00} as the handler address. Go to DONE.
- DONE, one cycle: oPC_SET=1, oPC_DATA=handler, oFINISH=1. Next state is IDLE.
- FAULT, one cycle: oFAULT=1, oFINISH=1, oPC_SET=0. Next state is IDLE.
- oBUSY = (state != IDLE).
- iCALL_START is ignored when not in IDLE; requests are not queued.
- iLDST_VALID is ignored outside the WAIT states, including a stale response arriving after a reset.

## Timing
- Reset values: state IDLE, all latches 0, every output 0.
- iRESET_SYNC has priority over all other transitions. It aborts any state, including mid-read, in the next cycle. No write, redirect or finish pulse is emitted after the abort.
- Minimum latency: start sampled at edge 0, then SAVE in cycle 1, FLAG_REQ in cycle 2, FLAG_WAIT in cycle 3 with valid in cycle 3, HDL_REQ in cycle 4, HDL_WAIT in cycle 5, DONE in cycle 6. oFINISH is high in cycle 6.
- Fault path minimum: oFINISH and oFAULT high in cycle 4.
- Each busy cycle adds one cycle. Each wait cycle before valid adds one cycle.
- A new iCALL_START can be accepted in the first IDLE cycle after DONE or FAULT.
- oPPCR_WR, oPPSR_WR, oPC_SET, oFAULT and oFINISH are each exactly one cycle wide per sequence.

## Test plan
- Normal call: IDTR=0x0000_1000, num=5, PC=0x0000_2344, PSR=0x0000_0003, memory returns flag 0x1 then handler 0x0000_8003, no busy.
  - Read addresses are 0x1028 and 0x102C.
  - PPCR=0x2344 and PPSR=0x3 are written in cycle 1.
  - oPC_DATA=0x8000 with oFINISH in cycle 6.
- Invalid entry: flag word 0x0.
  - oFAULT and oFINISH are high in cycle 4.
  - oPC_SET is never asserted and no handler read is issued.
- Backpressure: iLDST_BUSY high for 3 cycles on each request, with valid delayed 2 cycles.
  - oLDST_ADDR stays stable while oLDST_REQ is held.
  - oFINISH arrives in cycle 16.
- Address wrap: IDTR=0xFFFF_FFF8, num=1.
  - Reads go to 0x0000_0000 and 0x0000_0004.
- Reset mid-sequence: iRESET_SYNC in FLAG_WAIT, followed by a late iLDST_VALID.
  - The block returns to IDLE and ignores the late data.
  - No finish pulse.
  - The next start completes normally.
- Ignored start: iCALL_START pulses during HDL_WAIT.
  - No effect on the current sequence.
  - Exactly one oFINISH.

Source files
------------

// File: rtl/pipeline_control_irq_call.sv
// Interrupt-entry sequencer: saves the interrupted PC/PSR, fetches the 8-byte
// IDT entry for the interrupt number and redirects fetch to the handler or faults.
module pipeline_control_irq_call (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iCALL_START,
    input  logic [6:0]  iCALL_IRQ_NUM,
    input  logic [31:0] iCALL_PC,
    input  logic [31:0] iCALL_PSR,
    input  logic [31:0] iSYSREG_IDTR,
    output logic        oLDST_REQ,
    output logic [31:0] oLDST_ADDR,
    input  logic        iLDST_BUSY,
    input  logic        iLDST_VALID,
    input  logic [31:0] iLDST_DATA,
    output logic        oPPCR_WR,
    output logic [31:0] oPPCR_DATA,
    output logic        oPPSR_WR,
    output logic [31:0] oPPSR_DATA,
    output logic        oPC_SET,
    output logic [31:0] oPC_DATA,
    output logic        oFAULT,
    output logic        oBUSY,
    output logic        oFINISH
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SAVE      = 3'd1,
        ST_FLAG_REQ  = 3'd2,
        ST_FLAG_WAIT = 3'd3,
        ST_HDL_REQ   = 3'd4,
        ST_HDL_WAIT  = 3'd5,
        ST_DONE      = 3'd6,
        ST_FAULT     = 3'd7
    } state_t;

    state_t      state_reg, state_next;
    logic [6:0]  num_reg;
    logic [31:0] pc_reg;
    logic [31:0] psr_reg;
    logic [31:0] idtr_reg;
    logic [31:0] handler_reg;
    logic [31:0] entry_addr;
    logic        unused_ldst_bit;

    // Bit 1 of the IDT words carries no meaning for entry.
    assign unused_ldst_bit = iLDST_DATA[1];

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (iRESET_SYNC) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:      if (iCALL_START) state_next = ST_SAVE;
                ST_SAVE:      state_next = ST_FLAG_REQ;
                ST_FLAG_REQ:  if (!iLDST_BUSY) state_next = ST_FLAG_WAIT;
                ST_FLAG_WAIT: if (iLDST_VALID) state_next = iLDST_DATA[0] ? ST_HDL_REQ : ST_FAULT;
                ST_HDL_REQ:   if (!iLDST_BUSY) state_next = ST_HDL_WAIT;
                ST_HDL_WAIT:  if (iLDST_VALID) state_next = ST_DONE;
                ST_DONE:      state_next = ST_IDLE;
                ST_FAULT:     state_next = ST_IDLE;
                default:      state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            num_reg     <= '0;
            pc_reg      <= '0;
            psr_reg     <= '0;
            idtr_reg    <= '0;
            handler_reg <= '0;
        end else if (iRESET_SYNC) begin
            num_reg     <= '0;
            pc_reg      <= '0;
            psr_reg     <= '0;
            idtr_reg    <= '0;
            handler_reg <= '0;
        end else begin
            if (state_reg == ST_IDLE && iCALL_START) begin
                num_reg  <= iCALL_IRQ_NUM;
                pc_reg   <= iCALL_PC;
                psr_reg  <= iCALL_PSR;
                idtr_reg <= iSYSREG_IDTR;
            end
            if (state_reg == ST_HDL_WAIT && iLDST_VALID) begin
                handler_reg <= {iLDST_DATA[31:2], 2'b00};
            end
        end
    end

    // Entry base wraps naturally in 32-bit arithmetic.
    assign entry_addr = idtr_reg + {22'd0, num_reg, 3'b000};

    always_comb begin
        oLDST_REQ  = (state_reg == ST_FLAG_REQ) || (state_reg == ST_HDL_REQ);
        oLDST_ADDR = '0;
        if (state_reg == ST_FLAG_REQ) begin
            oLDST_ADDR = entry_addr;
        end else if (state_reg == ST_HDL_REQ) begin
            oLDST_ADDR = entry_addr + 32'd4;
        end
        oPPCR_WR   = (state_reg == ST_SAVE);
        oPPCR_DATA = (state_reg == ST_SAVE) ? pc_reg : '0;
        oPPSR_WR   = (state_reg == ST_SAVE);
        oPPSR_DATA = (state_reg == ST_SAVE) ? psr_reg : '0;
        oPC_SET    = (state_reg == ST_DONE);
        oPC_DATA   = (state_reg == ST_DONE) ? handler_reg : '0;
        oFAULT     = (state_reg == ST_FAULT);
        oFINISH    = (state_reg == ST_DONE) || (state_reg == ST_FAULT);
        oBUSY      = (state_reg != ST_IDLE);
    end

endmodule

// File: tb/tb_pipeline_control_irq_call.sv
// Bench for the interrupt-entry sequencer: directed test-plan cases and random
// calls against a transaction-level model of addresses, pulses and finish timing.
`timescale 1ns/1ps
module tb_pipeline_control_irq_call;

    logic        iCLOCK;
    logic        inRESET;
    logic        iRESET_SYNC;
    logic        iCALL_START;
    logic [6:0]  iCALL_IRQ_NUM;
    logic [31:0] iCALL_PC;
    logic [31:0] iCALL_PSR;
    logic [31:0] iSYSREG_IDTR;
    logic        oLDST_REQ;
    logic [31:0] oLDST_ADDR;
    logic        iLDST_BUSY;
    logic        iLDST_VALID;
    logic [31:0] iLDST_DATA;
    logic        oPPCR_WR;
    logic [31:0] oPPCR_DATA;
    logic        oPPSR_WR;
    logic [31:0] oPPSR_DATA;
    logic        oPC_SET;
    logic [31:0] oPC_DATA;
    logic        oFAULT;
    logic        oBUSY;
    logic        oFINISH;

    int vectors;
    int miscompares;

    pipeline_control_irq_call dut (
        .iCLOCK        (iCLOCK),
        .inRESET       (inRESET),
        .iRESET_SYNC   (iRESET_SYNC),
        .iCALL_START   (iCALL_START),
        .iCALL_IRQ_NUM (iCALL_IRQ_NUM),
        .iCALL_PC      (iCALL_PC),
        .iCALL_PSR     (iCALL_PSR),
        .iSYSREG_IDTR  (iSYSREG_IDTR),
        .oLDST_REQ     (oLDST_REQ),
        .oLDST_ADDR    (oLDST_ADDR),
        .iLDST_BUSY    (iLDST_BUSY),
        .iLDST_VALID   (iLDST_VALID),
        .iLDST_DATA    (iLDST_DATA),
        .oPPCR_WR      (oPPCR_WR),
        .oPPCR_DATA    (oPPCR_DATA),
        .oPPSR_WR      (oPPSR_WR),
        .oPPSR_DATA    (oPPSR_DATA),
        .oPC_SET       (oPC_SET),
        .oPC_DATA      (oPC_DATA),
        .oFAULT        (oFAULT),
        .oBUSY         (oBUSY),
        .oFINISH       (oFINISH)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete call. Cycle 1 is the first cycle after the edge that samples
    // the start. The model predicts the read addresses, SPR values, handler,
    // fault/finish outcome and finish cycle from the entry rules alone.
    task automatic run_call(input string name, input logic [6:0] num, input logic [31:0] pc,
                            input logic [31:0] psr, input logic [31:0] idtr,
                            input logic [31:0] flag_word, input logic [31:0] hdl_word,
                            input int b0, input int d0, input int b1, input int d1,
                            input int rst_cyc, input int ign_cyc, input int tail);
        int          busy_cfg [2];
        int          dly_cfg  [2];
        logic [31:0] word_cfg [2];
        logic [31:0] addr_q [$];
        logic [31:0] exp_addr [2];
        logic [31:0] addr_hold, resp_word, exp_hdl;
        bit          fault, req_active, pending;
        int          busy_left, wait_left, req_idx;
        int          exp_fin, last, fin_cyc;
        int          n_ppcr, n_ppsr, n_pcset, n_fault, n_fin;
        int          exp_reads;
        logic        exp_busy;

        busy_cfg[0] = b0; busy_cfg[1] = b1;
        dly_cfg[0]  = d0; dly_cfg[1]  = d1;
        word_cfg[0] = flag_word; word_cfg[1] = hdl_word;
        fault       = (flag_word[0] == 1'b0);
        exp_hdl     = hdl_word & 32'hFFFF_FFFC;
        exp_addr[0] = idtr + 32'(num) * 32'd8;
        exp_addr[1] = idtr + 32'(num) * 32'd8 + 32'd4;
        if (rst_cyc > 0)  exp_fin = -1;
        else if (fault)   exp_fin = 4 + b0 + d0;
        else              exp_fin = 6 + b0 + d0 + b1 + d1;
        exp_reads = (rst_cyc > 0 || fault) ? 1 : 2;
        last      = (exp_fin > 0) ? exp_fin + tail : rst_cyc + 10;
        req_active = 0; pending = 0; busy_left = 0; wait_left = 0; req_idx = 0;
        n_ppcr = 0; n_ppsr = 0; n_pcset = 0; n_fault = 0; n_fin = 0; fin_cyc = -1;
        addr_hold = '0; resp_word = '0;

        iCALL_START   = 1'b1;
        iCALL_IRQ_NUM = num;
        iCALL_PC      = pc;
        iCALL_PSR     = psr;
        iSYSREG_IDTR  = idtr;
        @(posedge iCLOCK); #1;
        iCALL_START   = 1'b0;
        iCALL_IRQ_NUM = 7'($urandom);
        iCALL_PC      = $urandom;
        iCALL_PSR     = $urandom;
        iSYSREG_IDTR  = $urandom;

        for (int cyc = 1; cyc <= last && cyc < 200; cyc++) begin
            if (oPPCR_WR) begin
                n_ppcr++;
                check("ppcr_cycle", 32'(cyc), 32'd1);
                check("ppcr_data", oPPCR_DATA, pc);
            end
            if (oPPSR_WR) begin
                n_ppsr++;
                check("ppsr_data", oPPSR_DATA, psr);
            end
            if (oPC_SET) begin
                n_pcset++;
                check("pc_data", oPC_DATA, exp_hdl);
                check("pc_set_with_finish", 32'(oFINISH), 32'd1);
            end
            if (oFAULT) begin
                n_fault++;
                check("fault_with_finish", 32'(oFINISH), 32'd1);
            end
            if (oFINISH) begin
                n_fin++;
                fin_cyc = cyc;
            end
            exp_busy = (rst_cyc > 0) ? (cyc <= rst_cyc) : (cyc <= exp_fin);
            check("busy", 32'(oBUSY), 32'(exp_busy));

            // Memory port model: busy stalls per request, then data after a delay.
            iLDST_VALID = 1'b0;
            iLDST_DATA  = $urandom;
            if (pending) begin
                if (wait_left == 0) begin
                    iLDST_VALID = 1'b1;
                    iLDST_DATA  = resp_word;
                    pending     = 0;
                end else begin
                    wait_left--;
                end
            end
            iLDST_BUSY = 1'b0;
            if (oLDST_REQ) begin
                if (!req_active) begin
                    req_active = 1;
                    busy_left  = (req_idx < 2) ? busy_cfg[req_idx] : 0;
                    addr_hold  = oLDST_ADDR;
                end else begin
                    check("addr_stable", oLDST_ADDR, addr_hold);
                end
                if (busy_left > 0) begin
                    iLDST_BUSY = 1'b1;
                    busy_left--;
                end else begin
                    addr_q.push_back(oLDST_ADDR);
                    req_active = 0;
                    pending    = 1;
                    wait_left  = (req_idx < 2) ? dly_cfg[req_idx] : 0;
                    resp_word  = (req_idx < 2) ? word_cfg[req_idx] : 32'h1;
                    req_idx++;
                end
            end
            iRESET_SYNC = (cyc == rst_cyc);
            iCALL_START = (cyc == ign_cyc);
            if (cyc == ign_cyc) begin
                iCALL_IRQ_NUM = num + 7'd3;
                iCALL_PC      = ~pc;
                iSYSREG_IDTR  = idtr + 32'h100;
            end
            @(posedge iCLOCK); #1;
        end
        iRESET_SYNC = 1'b0;
        iCALL_START = 1'b0;
        iLDST_BUSY  = 1'b0;
        iLDST_VALID = 1'b0;

        check("ppcr_count", 32'(n_ppcr), 32'd1);
        check("ppsr_count", 32'(n_ppsr), 32'd1);
        check("pc_set_count", 32'(n_pcset), (exp_fin > 0 && !fault) ? 32'd1 : 32'd0);
        check("fault_count", 32'(n_fault), (exp_fin > 0 && fault) ? 32'd1 : 32'd0);
        check("finish_count", 32'(n_fin), (exp_fin > 0) ? 32'd1 : 32'd0);
        if (exp_fin > 0) check("finish_cycle", 32'(fin_cyc), 32'(exp_fin));
        check("read_count", 32'(addr_q.size()), 32'(exp_reads));
        for (int i = 0; i < addr_q.size() && i < 2; i++) begin
            check("read_addr", addr_q[i], exp_addr[i]);
        end
        $display("call %-10s num=%0d idtr=%h pc=%h reads=%0d finish_cyc=%0d fault=%0d",
                 name, num, idtr, pc, addr_q.size(), fin_cyc, n_fault);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        inRESET       = 1'b0;
        iRESET_SYNC   = 1'b0;
        iCALL_START   = 1'b0;
        iCALL_IRQ_NUM = '0;
        iCALL_PC      = '0;
        iCALL_PSR     = '0;
        iSYSREG_IDTR  = '0;
        iLDST_BUSY    = 1'b0;
        iLDST_VALID   = 1'b0;
        iLDST_DATA    = '0;

        #1;
        check("reset_ctrl", {26'd0, oLDST_REQ, oPPCR_WR, oPPSR_WR, oPC_SET, oFAULT, oFINISH}, 32'd0);
        check("reset_busy", 32'(oBUSY), 32'd0);
        #22;
        check("reset_data", oLDST_ADDR | oPPCR_DATA | oPPSR_DATA | oPC_DATA, 32'd0);
        inRESET = 1'b1;
        @(posedge iCLOCK); #1;
        check("idle_busy", 32'(oBUSY), 32'd0);

        run_call("normal", 7'd5, 32'h0000_2344, 32'h0000_0003, 32'h0000_1000,
                 32'h1, 32'h0000_8003, 0, 0, 0, 0, 0, 0, 2);
        run_call("invalid", 7'd9, 32'h0000_4000, 32'h0000_0001, 32'h0000_2000,
                 32'h0, 32'h0000_9000, 0, 0, 0, 0, 0, 0, 2);
        run_call("backpres", 7'd17, 32'h1234_5678, 32'h0000_00F0, 32'h0001_0000,
                 32'h1, 32'hCAFE_BABF, 3, 2, 3, 2, 0, 0, 2);
        run_call("wrap", 7'd1, 32'h0000_0100, 32'h0000_0002, 32'hFFFF_FFF8,
                 32'h1, 32'h0000_0400, 0, 0, 0, 0, 0, 0, 2);
        run_call("reset_mid", 7'd3, 32'h0000_0500, 32'h0000_0007, 32'h0000_3000,
                 32'h1, 32'h0000_7000, 0, 3, 0, 0, 4, 0, 0);
        run_call("post_rst", 7'd3, 32'h0000_0504, 32'h0000_0006, 32'h0000_3000,
                 32'h1, 32'h0000_7100, 0, 0, 0, 0, 0, 0, 1);
        run_call("ign_start", 7'd12, 32'h0000_0A00, 32'h0000_0005, 32'h0000_5000,
                 32'h1, 32'h0000_6006, 0, 0, 0, 2, 0, 6, 4);

        for (int t = 0; t < 20; t++) begin
            logic [31:0] flag_w;
            flag_w = $urandom;
            if ($urandom_range(0, 3) != 0) flag_w[0] = 1'b1;
            run_call("random", 7'($urandom), $urandom, $urandom, $urandom, flag_w, $urandom,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     0, 0, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
